// File: rtl/ysyx_24090018_mc_seq.sv
// Multi-cycle core sequencer: steps each instruction through
// FETCH -> DECODE -> EXEC -> [MEM] -> WB, bounds fetch and memory waits
// with a timeout, and keeps the mcycle/minstret performance counters.
module ysyx_24090018_mc_seq #(
  parameter int CNT_WIDTH = 32,
  parameter int TIMEOUT   = 200
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 ifu_req_o,
  input  logic                 ifu_rvalid_i,
  output logic                 inst_en_o,
  input  logic                 MemRead_i,
  input  logic                 MemWrite_i,
  input  logic                 RegWrite_i,
  input  logic                 stop_flag_i,
  output logic                 lsu_req_o,
  output logic                 lsu_we_o,
  input  logic                 lsu_done_i,
  output logic                 rf_we_o,
  output logic                 pc_we_o,
  output logic                 halt_o,
  output logic                 err_o,
  output logic [2:0]           state_o,
  output logic [CNT_WIDTH-1:0] mcycle_o,
  output logic [CNT_WIDTH-1:0] minstret_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6,
    ERR    = 3'd7
  } state_t;

  // Last wait-counter value before a missing response becomes an error.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_n;
  logic [7:0] wait_cnt;
  logic       reg_write_q;
  logic       timed_out;
  logic       counting;

  assign timed_out = (wait_cnt == WAIT_LAST);
  assign counting  = (state != IDLE) && (state != HALT) && (state != ERR);
  assign state_o   = state;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state and output decode; outputs are purely a function of the
  // current state (plus response inputs), so reset forces them low at once.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_n   = state;
    ifu_req_o = 1'b0;
    inst_en_o = 1'b0;
    lsu_req_o = 1'b0;
    lsu_we_o  = 1'b0;
    rf_we_o   = 1'b0;
    pc_we_o   = 1'b0;
    halt_o    = 1'b0;
    err_o     = 1'b0;
    unique case (state)
      IDLE:   state_n = FETCH;
      FETCH: begin
        ifu_req_o = 1'b1;
        if (ifu_rvalid_i) begin
          inst_en_o = 1'b1;
          state_n   = DECODE;
        end else if (timed_out) begin
          state_n = ERR;
        end
      end
      DECODE: state_n = stop_flag_i ? HALT : EXEC;
      EXEC:   state_n = (MemRead_i | MemWrite_i) ? MEM : WB;
      MEM: begin
        lsu_req_o = 1'b1;
        lsu_we_o  = MemWrite_i;
        if (lsu_done_i)     state_n = WB;
        else if (timed_out) state_n = ERR;
      end
      WB: begin
        pc_we_o = 1'b1;
        rf_we_o = reg_write_q;
        state_n = FETCH;
      end
      HALT:   halt_o = 1'b1;
      ERR:    err_o  = 1'b1;
      default: state_n = IDLE;
    endcase
  end

  // Wait counter: zeroed on any state change (covers entry to FETCH/MEM),
  // counts each FETCH/MEM cycle spent waiting for a response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                wait_cnt <= '0;
    else if (state_n != state)                 wait_cnt <= '0;
    else if ((state == FETCH) || (state == MEM)) wait_cnt <= wait_cnt + 8'd1;
  end

  // Register-write flag is captured only while decode outputs are valid,
  // so WB is immune to the decode stage moving on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      reg_write_q <= 1'b0;
    else if ((state == DECODE) || (state == EXEC) || (state == MEM))
      reg_write_q <= RegWrite_i;
  end

  // Performance counters; both wrap naturally at 2^CNT_WIDTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcycle_o   <= '0;
      minstret_o <= '0;
    end else begin
      if (counting)    mcycle_o   <= mcycle_o + 1'b1;
      if (state == WB) minstret_o <= minstret_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_ysyx_24090018_mc_seq.sv
// Directed bench for the multi-cycle sequencer: ALU, load, store, reset
// abort, halt, and timeout behaviour with hand-computed expectations.
module tb_ysyx_24090018_mc_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifu_rvalid, mem_read, mem_write, reg_write, stop_flag, lsu_done;
  logic        ifu_req, inst_en, lsu_req, lsu_we, rf_we, pc_we, halt, err;
  logic [2:0]  state;
  logic [31:0] mcycle, minstret;

  // Short-timeout instance with its own reset and fetch response.
  logic        rst2_n, ifu_rvalid2;
  logic        ifu_req2, inst_en2, lsu_req2, lsu_we2, rf_we2, pc_we2, halt2, err2;
  logic [2:0]  state2;
  logic [31:0] mcycle2, minstret2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ysyx_24090018_mc_seq u_dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_o(ifu_req), .ifu_rvalid_i(ifu_rvalid), .inst_en_o(inst_en),
    .MemRead_i(mem_read), .MemWrite_i(mem_write), .RegWrite_i(reg_write),
    .stop_flag_i(stop_flag), .lsu_req_o(lsu_req), .lsu_we_o(lsu_we),
    .lsu_done_i(lsu_done), .rf_we_o(rf_we), .pc_we_o(pc_we),
    .halt_o(halt), .err_o(err), .state_o(state),
    .mcycle_o(mcycle), .minstret_o(minstret)
  );

  ysyx_24090018_mc_seq #(.CNT_WIDTH(32), .TIMEOUT(4)) u_dut_t4 (
    .clk(clk), .rst_n(rst2_n),
    .ifu_req_o(ifu_req2), .ifu_rvalid_i(ifu_rvalid2), .inst_en_o(inst_en2),
    .MemRead_i(1'b0), .MemWrite_i(1'b0), .RegWrite_i(1'b0),
    .stop_flag_i(1'b0), .lsu_req_o(lsu_req2), .lsu_we_o(lsu_we2),
    .lsu_done_i(1'b0), .rf_we_o(rf_we2), .pc_we_o(pc_we2),
    .halt_o(halt2), .err_o(err2), .state_o(state2),
    .mcycle_o(mcycle2), .minstret_o(minstret2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; returns 2 time units after the rising edge so new
  // state is visible and inputs can be set for the current cycle.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // All 1-bit outputs of the main instance packed for zero checks.
  function automatic logic [31:0] outs1();
    return {24'd0, ifu_req, inst_en, lsu_req, lsu_we, rf_we, pc_we, halt, err};
  endfunction

  initial begin
    rst_n = 1'b0; rst2_n = 1'b0;
    ifu_rvalid = 0; mem_read = 0; mem_write = 0; reg_write = 0;
    stop_flag = 0; lsu_done = 0; ifu_rvalid2 = 0;

    // ---- reset state
    tick();
    check("rst_state", {29'd0, state}, 32'd0);
    check("rst_outs", outs1(), 32'd0);
    check("rst_mcycle", mcycle, 32'd0);
    check("rst_minstret", minstret, 32'd0);

    // ---- ALU instruction, fetch response on 3rd FETCH cycle
    rst_n = 1'b1;
    #1 check("alu_idle", {29'd0, state}, 32'd0);
    tick(); check("alu_fetch1", {29'd0, state}, 32'd1);
    check("alu_ifu_req", {31'd0, ifu_req}, 32'd1);
    check("alu_no_inst_en", {31'd0, inst_en}, 32'd0);
    tick(); check("alu_fetch2", {29'd0, state}, 32'd1);
    tick(); check("alu_fetch3", {29'd0, state}, 32'd1);
    ifu_rvalid = 1;
    #1 check("alu_inst_en", {31'd0, inst_en}, 32'd1);
    tick(); ifu_rvalid = 0; reg_write = 1;
    check("alu_decode", {29'd0, state}, 32'd2);
    check("alu_dec_ifu_req", {31'd0, ifu_req}, 32'd0);
    tick(); check("alu_exec", {29'd0, state}, 32'd3);
    tick(); check("alu_wb", {29'd0, state}, 32'd5);
    check("alu_wb_rf_we", {31'd0, rf_we}, 32'd1);
    check("alu_wb_pc_we", {31'd0, pc_we}, 32'd1);
    tick(); check("alu_refetch", {29'd0, state}, 32'd1);
    check("alu_rf_we_off", {31'd0, rf_we}, 32'd0);
    check("alu_pc_we_off", {31'd0, pc_we}, 32'd0);
    check("alu_minstret", minstret, 32'd1);
    check("alu_mcycle", mcycle, 32'd6);

    // ---- load, lsu_done on 3rd MEM cycle
    ifu_rvalid = 1;
    tick(); ifu_rvalid = 0; mem_read = 1; reg_write = 1;
    tick(); check("ld_exec", {29'd0, state}, 32'd3);
    tick(); check("ld_mem1", {29'd0, state}, 32'd4);
    check("ld_req1", {30'd0, lsu_req, lsu_we}, 32'b10);
    tick(); check("ld_req2", {30'd0, lsu_req, lsu_we}, 32'b10);
    tick(); check("ld_req3", {30'd0, lsu_req, lsu_we}, 32'b10);
    lsu_done = 1;
    tick(); lsu_done = 0;
    check("ld_wb", {29'd0, state}, 32'd5);
    check("ld_wb_lsu_req", {31'd0, lsu_req}, 32'd0);
    check("ld_wb_rf_we", {31'd0, rf_we}, 32'd1);
    tick(); check("ld_minstret", minstret, 32'd2);
    mem_read = 0;

    // ---- store with both memory flags, no register write
    ifu_rvalid = 1;
    tick(); ifu_rvalid = 0; mem_read = 1; mem_write = 1; reg_write = 0;
    tick(); tick();
    check("st_mem1", {29'd0, state}, 32'd4);
    check("st_we1", {30'd0, lsu_req, lsu_we}, 32'b11);
    tick(); check("st_we2", {30'd0, lsu_req, lsu_we}, 32'b11);
    lsu_done = 1;
    tick(); lsu_done = 0;
    check("st_wb_pc_we", {31'd0, pc_we}, 32'd1);
    check("st_wb_rf_we", {31'd0, rf_we}, 32'd0);
    tick(); check("st_minstret", minstret, 32'd3);

    // ---- reset pulsed mid-MEM aborts without a clock edge
    mem_write = 0; reg_write = 1; ifu_rvalid = 1;
    tick(); ifu_rvalid = 0;
    tick(); tick();
    check("ra_in_mem", {30'd0, lsu_req, lsu_we}, 32'b10);
    rst_n = 1'b0;
    #1 check("ra_outs", outs1(), 32'd0);
    check("ra_state", {29'd0, state}, 32'd0);
    check("ra_mcycle", mcycle, 32'd0);
    check("ra_minstret", minstret, 32'd0);
    lsu_done = 1;
    tick(); check("ra_held", outs1(), 32'd0);
    lsu_done = 0; mem_read = 0; reg_write = 0;
    rst_n = 1'b1;
    #1 check("ra_idle", {29'd0, state}, 32'd0);
    tick(); check("ra_fetch", {29'd0, state}, 32'd1);

    // ---- ebreak -> HALT, absorbing, mcycle frozen
    ifu_rvalid = 1;
    tick(); ifu_rvalid = 0; stop_flag = 1;
    tick(); stop_flag = 0;
    check("hl_state", {29'd0, state}, 32'd6);
    check("hl_halt", {31'd0, halt}, 32'd1);
    check("hl_pc_we", {31'd0, pc_we}, 32'd0);
    for (int i = 0; i < 100; i++) begin
      ifu_rvalid = i[0]; mem_read = i[1]; lsu_done = i[2]; reg_write = i[0];
      tick();
    end
    ifu_rvalid = 0; mem_read = 0; lsu_done = 0; reg_write = 0;
    check("hl_state_100", {29'd0, state}, 32'd6);
    check("hl_outs_100", outs1(), 32'b10);
    check("hl_mcycle", mcycle, 32'd2);
    check("hl_minstret", minstret, 32'd0);

    // ---- TIMEOUT=4: no response -> ERR after 4 FETCH cycles
    rst2_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("to_fetch%0d", i + 1), {29'd0, state2}, 32'd1);
      tick();
    end
    check("to_err_state", {29'd0, state2}, 32'd7);
    check("to_err", {31'd0, err2}, 32'd1);
    check("to_err_ifu_req", {31'd0, ifu_req2}, 32'd0);
    ifu_rvalid2 = 1;
    tick(); tick(); ifu_rvalid2 = 0;
    check("to_err_sticky", {29'd0, state2}, 32'd7);

    // ---- TIMEOUT=4: response on the 4th cycle wins
    rst2_n = 1'b0;
    #1 check("to_rst_err", {31'd0, err2}, 32'd0);
    tick(); rst2_n = 1'b1;
    tick(); tick(); tick(); tick();
    check("to_fetch4b", {29'd0, state2}, 32'd1);
    ifu_rvalid2 = 1;
    tick(); ifu_rvalid2 = 0;
    check("to_win_state", {29'd0, state2}, 32'd2);
    check("to_win_err", {31'd0, err2}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_24090018_mc_seq.md
YSYX_24090018_MC_SEQ -- requirements
Module: ysyx_24090018_mc_seq

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 32: width of the cycle and instruction-retired counters.
REQ-002 SHALL have parameter TIMEOUT, default 200: wait cycles allowed for a fetch or memory response, range 1..255.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port ifu_req_o  out  1  instruction fetch request, level, held until accepted.
REQ-006 SHALL have port ifu_rvalid_i  in  1  fetch response valid; instruction present on the fetch bus this cycle.
REQ-007 SHALL have port inst_en_o  out  1  instruction-register load strobe.
REQ-008 SHALL have port MemRead_i  in  1  decoded load flag from the decode stage.
REQ-009 SHALL have port MemWrite_i  in  1  decoded store flag from the decode stage.
REQ-010 SHALL have port RegWrite_i  in  1  decoded register-write flag.
REQ-011 SHALL have port stop_flag_i  in  1  decoded ebreak.
REQ-012 SHALL have port lsu_req_o  out  1  memory request, level, held until done.
REQ-013 SHALL have port lsu_we_o  out  1  1=store, 0=load; valid while lsu_req_o=1.
REQ-014 SHALL have port lsu_done_i  in  1  memory access complete.
REQ-015 SHALL have port rf_we_o  out  1  gated register-file write enable.
REQ-016 SHALL have port pc_we_o  out  1  PC update strobe.
REQ-017 SHALL have port halt_o  out  1  core halted by ebreak, sticky.
REQ-018 SHALL have port err_o  out  1  response timeout, sticky.
REQ-019 SHALL have port state_o  out  3  current state encoding, for debug.
REQ-020 SHALL have port mcycle_o  out  CNT_WIDTH  cycle count.
REQ-021 SHALL have port minstret_o  out  CNT_WIDTH  retired-instruction count.

Function
REQ-022 SHALL use these state encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, ERR=7.
REQ-023 SHALL move IDLE->FETCH unconditionally on the first clock edge after rst_n deasserts.
REQ-024 FETCH: SHALL drive ifu_req_o=1; on ifu_rvalid_i=1, inst_en_o=1 combinationally that same cycle and next state is DECODE; otherwise the block stays in FETCH.
REQ-025 DECODE: SHALL go to HALT if stop_flag_i=1, else to EXEC, after exactly one cycle.
REQ-026 EXEC: SHALL last one cycle, then go to MEM if MemRead_i|MemWrite_i, else to WB.
REQ-027 MEM: SHALL drive lsu_req_o=1 and lsu_we_o=MemWrite_i, with store winning if both flags are set; on lsu_done_i=1 next state is WB.
REQ-028 WB: SHALL assert pc_we_o=1 and rf_we_o=RegWrite_i for exactly one cycle, then go to FETCH.
REQ-029 Outside WB, rf_we_o and pc_we_o SHALL be 0; outside MEM, lsu_req_o and lsu_we_o SHALL be 0; outside FETCH, ifu_req_o and inst_en_o SHALL be 0.
REQ-030 Wait counter, 8 bits: SHALL clear on entry to FETCH or MEM and increment on each FETCH/MEM cycle without a response.
REQ-031 SHALL move to ERR on the cycle the counter equals TIMEOUT-1 with no response.
REQ-032 A response arriving on the same cycle as the timeout SHALL win, and the block proceeds normally.
REQ-033 HALT and ERR SHALL be absorbing until reset; halt_o=1 in HALT, err_o=1 in ERR, and all request and strobe outputs are 0.
REQ-034 mcycle_o SHALL increment every cycle except in IDLE, HALT and ERR, wrapping modulo 2^CNT_WIDTH.
REQ-035 minstret_o SHALL increment by 1 on each WB cycle, wrapping modulo 2^CNT_WIDTH.
REQ-036 Decode inputs SHALL be sampled only in DECODE, EXEC and MEM; changes in other states SHALL have no effect.

Reset
REQ-037 While rst_n=0, SHALL immediately force state=IDLE, wait counter=0, mcycle_o=0, minstret_o=0, and every 1-bit output to 0, independent of clk.
REQ-038 Reset asserted mid-operation (any state, including MEM with lsu_req_o=1) SHALL abort the instruction with no write strobe issued.

Verification
REQ-039 Reset release, ifu_rvalid_i high on the 3rd FETCH cycle, RegWrite_i=1, no memory flags -> state_o 0,1,1,1,2,3,5,1; rf_we_o=pc_we_o=1 for one cycle; minstret_o=1.
REQ-040 Load (MemRead_i=1), lsu_done_i on the 3rd MEM cycle -> lsu_req_o=1 for 3 cycles, lsu_we_o=0, then WB with rf_we_o=1.
REQ-041 Store with MemRead_i=MemWrite_i=1, RegWrite_i=0 -> lsu_we_o=1 throughout MEM; WB gives pc_we_o=1, rf_we_o=0.
REQ-042 stop_flag_i=1 in DECODE -> HALT (state_o=6), halt_o=1, pc_we_o=0, and the block stays halted for 100 cycles with mcycle_o frozen.
REQ-043 TIMEOUT=4, ifu_rvalid_i held 0 -> 4 FETCH cycles, then state_o=7 and err_o=1; repeat with ifu_rvalid_i=1 on the 4th cycle -> DECODE, err_o=0.
REQ-044 rst_n pulsed low during MEM -> all outputs 0 within the same cycle, no clock edge needed; after release, IDLE then FETCH.
